// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation-control monitor: FSM states, console entry
// layout and a helper that sizes the console channel field.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam int CHAN_MAX_W = 8;

    typedef struct packed {
        logic [CHAN_MAX_W-1:0] chan;
        logic [7:0]            chr;
    } con_entry_t;

    function automatic int chan_width(input int n_console);
        return (n_console > 1) ? $clog2(n_console) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head is held in a register refreshed from
// the RAM array (or forwarded from the write port) so rdata is valid the cycle after a push.
module sync_fifo #(
    parameter int  WIDTH = 9,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_addr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rdata_reg;
    logic             push_en;
    logic             pop_en;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign rdata   = rdata_reg;
    assign pop_en  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign rd_addr_next = pop_en ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_addr_next;
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: ;
            endcase
            // Forward the incoming word when it lands exactly on the next head slot.
            if (push_en && (wr_ptr_reg == rd_addr_next)) begin
                rdata_reg <= wdata;
            end else begin
                rdata_reg <= mem[rd_addr_next];
            end
        end
    end

endmodule

// File: rtl/sim_ctrl_monitor.sv
// Snoops the DCCM write port for finish/console addresses, queues console
// characters, tracks cycles and retirements, and times out a stalled core.
module sim_ctrl_monitor
    import sim_ctrl_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  FINISH_ADDR  = 32'h1000_0000,
    parameter logic [XLEN-1:0]  CONSOLE_BASE = 32'h0020_0000,
    parameter int               N_CONSOLE    = 2,
    parameter int               RET_LANES    = 3,
    parameter int               FIFO_DEPTH   = 16,
    parameter int               WDOG_LIMIT   = 1000,
    parameter int               CNT_W        = 32,
    localparam int              CH_W         = chan_width(N_CONSOLE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dccm_wen,
    input  logic [XLEN-1:0]      dccm_waddr,
    input  logic [XLEN-1:0]      dccm_wdata,
    input  logic [RET_LANES-1:0] retire_valid,
    output logic                 con_valid,
    input  logic                 con_ready,
    output logic [CH_W-1:0]      con_chan,
    output logic [7:0]           con_char,
    output logic                 finish_req,
    output logic [XLEN-1:0]      finish_code,
    output logic                 wdog_timeout,
    output logic                 con_overflow,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     retire_count
);

    localparam int RC_W   = $clog2(RET_LANES + 1);
    localparam int IDLE_W = $clog2(WDOG_LIMIT + 1);
    localparam int FW     = CH_W + 8;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e               state_reg;
    logic [IDLE_W-1:0]    idle_cnt_reg;
    logic [CNT_W-1:0]     drop_cnt_reg;
    logic [N_CONSOLE-1:0] con_hit;
    logic [CH_W-1:0]      hit_chan;
    logic [RC_W-1:0]      retire_pop;
    logic                 finish_hit;
    logic                 retire_any;
    logic                 in_run;
    logic                 active;
    logic                 wdog_fire;
    logic                 con_push_req;
    logic                 con_pop;
    logic                 fifo_push;
    logic                 con_drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FCNT_W-1:0]    fifo_count;
    logic [FW-1:0]        fifo_wdata;
    logic [FW-1:0]        fifo_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < N_CONSOLE; gi++) begin : g_con_decode
            assign con_hit[gi] = dccm_wen && (dccm_waddr == (CONSOLE_BASE + XLEN'(4 * gi)));
        end
    endgenerate

    always_comb begin
        hit_chan = '0;
        for (int i = 0; i < N_CONSOLE; i++) begin
            if (con_hit[i]) begin
                hit_chan = CH_W'(i);
            end
        end
    end

    always_comb begin
        retire_pop = '0;
        for (int i = 0; i < RET_LANES; i++) begin
            retire_pop = retire_pop + RC_W'(retire_valid[i]);
        end
    end

    assign finish_hit   = dccm_wen && (dccm_waddr == FINISH_ADDR);
    assign retire_any   = |retire_valid;
    assign in_run       = (state_reg == RUN);
    assign active       = in_run || (state_reg == DRAIN);
    assign wdog_fire    = active && !retire_any && (idle_cnt_reg == IDLE_W'(WDOG_LIMIT));
    assign con_valid    = (fifo_count != '0);
    assign con_pop      = con_valid && con_ready;
    // Console traffic after the finish write is discarded without flagging overflow.
    assign con_push_req = in_run && (|con_hit);
    assign fifo_push    = con_push_req && (!fifo_full || con_pop);
    assign con_drop     = con_push_req && !fifo_push;
    assign fifo_wdata   = {hit_chan, dccm_wdata[7:0]};
    assign con_chan     = fifo_rdata[FW-1:8];
    assign con_char     = fifo_rdata[7:0];

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (con_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Watchdog takes priority over a finish write arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            finish_req   <= 1'b0;
            finish_code  <= '0;
            wdog_timeout <= 1'b0;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (wdog_fire) begin
                        state_reg    <= TIMEOUT;
                        wdog_timeout <= 1'b1;
                    end else if (finish_hit) begin
                        state_reg   <= DRAIN;
                        finish_code <= dccm_wdata;
                    end
                end
                DRAIN: begin
                    if (wdog_fire) begin
                        state_reg    <= TIMEOUT;
                        wdog_timeout <= 1'b1;
                    end else if (fifo_empty) begin
                        state_reg  <= DONE;
                        finish_req <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_reg <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            drop_cnt_reg <= '0;
            con_overflow <= 1'b0;
        end else begin
            if (active) begin
                cycle_count <= cycle_count + CNT_W'(1);
                if (retire_any) begin
                    idle_cnt_reg <= '0;
                end else if (idle_cnt_reg != IDLE_W'(WDOG_LIMIT)) begin
                    idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
                end
            end
            retire_count <= retire_count + CNT_W'(retire_pop);
            if (con_drop) begin
                con_overflow <= 1'b1;
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule
